// File: rtl/mem_pkg.sv
// Shared definitions for the memory unit: loader state encoding and the
// fixed program/data region boundaries of the 256-byte address map.
package mem_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LOAD    = 2'd1,
      ST_RELEASE = 2'd2
   } load_state_t;

   localparam logic [7:0] PROG_BASE = 8'h00;
   localparam logic [7:0] PROG_LAST = 8'h7F;
   localparam logic [7:0] DATA_BASE = 8'hF0;

   // Offset form avoids an always-true compare when PROG_BASE is zero.
   function automatic logic is_prog_addr(input logic [7:0] addr);
      return (addr - PROG_BASE) <= (PROG_LAST - PROG_BASE);
   endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage with one synchronous write port and one asynchronous read
// port; read-after-write sees the new word from the cycle after the edge.
module mem_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

   // NOTE: storage has no reset on purpose; contents must survive a reset
   // that aborts a load, and a reset port would block RAM inference.
   always_ff @(posedge clock) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/memory_unit.sv
// CPU-facing memory with a streaming program loader that holds the CPU in
// reset while loading. Define PROG_WP_EN to drop CPU writes to 0x00-0x7F.
module memory_unit
   import mem_pkg::*;
#(
   parameter int                ADDR_W         = 8,
   parameter int                DATA_W         = 8,
   parameter logic [ADDR_W-1:0] LOAD_LAST_ADDR = 8'hFF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] mar,
   inout  wire  [DATA_W-1:0] mbr,
   input  logic              we,
   output logic              cpu_rst,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_busy,
   output logic              load_err,
   output logic [ADDR_W-1:0] load_count,
   output logic              wp_hit
);

   load_state_t       r_state;
   load_state_t       w_next_state;
   // The load address and the byte count always move together.
   logic [ADDR_W-1:0] r_load_addr;
   logic              r_load_err;

   logic              w_accept;
   logic              w_at_last;
   logic              w_overflow;
   logic              w_cpu_we;
   logic              w_cpu_blocked;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_data;
   logic [DATA_W-1:0] w_rdata;

   assign w_accept   = (r_state == ST_LOAD) && load_valid;
   assign w_at_last  = (r_load_addr == LOAD_LAST_ADDR);
   assign w_overflow = w_accept && w_at_last && !load_last;
   assign w_cpu_we   = (r_state == ST_RUN) && we;

`ifdef PROG_WP_EN
   assign w_cpu_blocked = w_cpu_we && is_prog_addr(8'(mar));
`else
   assign w_cpu_blocked = 1'b0;
`endif

   // NOTE: non-blocking assignment for every clocked register so all flops
   // sample pre-edge values regardless of process ordering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= ST_RELEASE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_RUN:     if (load_start) w_next_state = ST_LOAD;
         ST_LOAD:    if (w_accept && (load_last || w_at_last)) w_next_state = ST_RELEASE;
         ST_RELEASE: w_next_state = ST_RUN;
         default:    w_next_state = ST_RELEASE;
      endcase
   end

   always_comb begin
      cpu_rst    = 1'b1;
      load_ready = 1'b0;
      load_busy  = 1'b0;
      case (r_state)
         ST_RUN:  cpu_rst = 1'b0;
         ST_LOAD: begin
            load_ready = 1'b1;
            load_busy  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_load_addr <= '0;
         r_load_err  <= 1'b0;
      end else if ((r_state == ST_RUN) && load_start) begin
         r_load_addr <= '0;
         r_load_err  <= 1'b0;
      end else if (w_accept) begin
         r_load_addr <= r_load_addr + 1'b1;
         if (w_overflow) r_load_err <= 1'b1;
      end
   end

   // NOTE: every output of this block gets a default first so no path can
   // infer a latch.
   always_comb begin
      w_mem_we   = 1'b0;
      w_mem_addr = mar;
      w_mem_data = mbr;
      if (w_accept) begin
         w_mem_we   = 1'b1;
         w_mem_addr = r_load_addr;
         w_mem_data = load_data;
      end else if (w_cpu_we && !w_cpu_blocked) begin
         w_mem_we = 1'b1;
      end
   end

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem_array (
      .clock   (clock),
      .i_we    (w_mem_we),
      .i_waddr (w_mem_addr),
      .i_wdata (w_mem_data),
      .i_raddr (mar),
      .o_rdata (w_rdata)
   );

   assign mbr        = ((r_state == ST_RUN) && !we) ? w_rdata : {DATA_W{1'bz}};
   assign load_count = r_load_addr;
   assign load_err   = r_load_err;
   assign wp_hit     = w_cpu_blocked;

endmodule
